// File: rtl/apbspi_wm_fifo.sv
// Data FIFO between the APB register file and the SPI shift engine, with
// occupancy count, almost-full/empty watermarks, watermark event and sticky error flags.
module apbspi_wm_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [LVL_W-1:0] af_level,
    input  logic [LVL_W-1:0] ae_level,
    output logic [WIDTH-1:0] read_data,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             af_event,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    // Reject depths the natural pointer wrap cannot represent.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LVL_W != PTR_W + 1) begin : g_param_check
            $error("apbspi_wm_fifo: DEPTH must be a power of two >= 2 and LVL_W = clog2(DEPTH)+1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             af_event_q, af_event_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;
    logic ovf_set;
    logic udf_set;

    // Status decoded from the occupancy register.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_MAX);
    assign almost_full  = (level_q >= af_level);
    assign almost_empty = (level_q <= ae_level);

    assign read_data = mem[rd_ptr_q];
    assign level     = level_q;
    assign af_event  = af_event_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next-state: accept rules, pointer/level update, watermark event, sticky errors.
    always_comb begin
        push_ok     = push & (~full | pop) & ~flush;
        pop_ok      = pop & ~empty & ~flush;
        ovf_set     = push & full & ~pop & ~flush;
        udf_set     = pop & empty & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        // Only a rising crossing of the threshold by the level itself counts.
        af_event_d = ~flush & (level_q < af_level) & (level_d >= af_level);

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end
        if (udf_set) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            af_event_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            af_event_q  <= af_event_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= write_data;
        end
    end

endmodule

// File: tb/tb_apbspi_wm_fifo.sv
// Bench for apbspi_wm_fifo (WIDTH=8, DEPTH=4): directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_apbspi_wm_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = 3;

    logic             clk;
    logic             nrst;
    logic             push;
    logic             pop;
    logic             flush;
    logic             err_clr;
    logic [WIDTH-1:0] write_data;
    logic [LVL_W-1:0] af_level;
    logic [LVL_W-1:0] ae_level;
    logic [WIDTH-1:0] read_data;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             af_event;
    logic             overflow;
    logic             underflow;

    apbspi_wm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .err_clr      (err_clr),
        .write_data   (write_data),
        .af_level     (af_level),
        .ae_level     (ae_level),
        .read_data    (read_data),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .af_event     (af_event),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as a queue plus the three flag bits.
    logic [WIDTH-1:0] q[$];
    bit m_ovf = 0;
    bit m_udf = 0;
    bit m_afe = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int sz = q.size();
        check({tag, ".level"}, 32'(level), 32'(sz));
        check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        check({tag, ".afull"}, 32'(almost_full), 32'(sz >= int'(af_level)));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= int'(ae_level)));
        check({tag, ".af_event"}, 32'(af_event), 32'(m_afe));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        if (sz > 0) check({tag, ".rdata"}, 32'(read_data), 32'(q[0]));
    endtask

    // Drive one cycle of requests, advance the model at the edge, then compare.
    task automatic cycle(input string tag, input bit p, input bit po, input bit fl,
                         input bit ec, input logic [WIDTH-1:0] d);
        int  old;
        bit  ovf_set, udf_set;
        push = p; pop = po; flush = fl; err_clr = ec; write_data = d;
        @(posedge clk);
        old = q.size();
        ovf_set = 0;
        udf_set = 0;
        if (fl) begin
            q.delete();
        end else begin
            ovf_set = p && old == DEPTH && !po;
            udf_set = po && old == 0;
            if (po && old > 0) void'(q.pop_front());
            if (p && (old < DEPTH || po)) q.push_back(d);
        end
        m_afe = !fl && old < int'(af_level) && q.size() >= int'(af_level);
        if (ovf_set) m_ovf = 1; else if (ec) m_ovf = 0;
        if (udf_set) m_udf = 1; else if (ec) m_udf = 0;
        #1;
        push = 0; pop = 0; flush = 0; err_clr = 0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_afe = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        nrst = 0; push = 0; pop = 0; flush = 0; err_clr = 0;
        write_data = '0; af_level = 3'd3; ae_level = 3'd1;
        model_reset();
        #23;
        check_all("reset");
        nrst = 1;
        @(posedge clk); #1;

        // Fill to full.
        cycle("fill1", 1, 0, 0, 0, 8'h11);
        cycle("fill2", 1, 0, 0, 0, 8'h22);
        cycle("fill3", 1, 0, 0, 0, 8'h33);
        check("fill3_af_pulse", 32'(af_event), 32'd1);
        cycle("fill4", 1, 0, 0, 0, 8'h44);
        check("fill4_full", 32'(full), 32'd1);
        check("fill4_head", 32'(read_data), 32'h11);

        // Overflow, then clear.
        cycle("ovf", 1, 0, 0, 0, 8'h55);
        check("ovf_flag", 32'(overflow), 32'd1);
        cycle("errclr", 0, 0, 0, 1, 8'h00);

        // Push and pop together at full, then drain.
        cycle("full_pp", 1, 1, 0, 0, 8'h55);
        check("full_pp_head", 32'(read_data), 32'h22);
        for (int i = 0; i < 4; i++) cycle("drain", 0, 1, 0, 0, 8'h00);
        check("drain_empty", 32'(empty), 32'd1);

        // Underflow and push+pop on empty.
        cycle("udf", 0, 1, 0, 0, 8'h00);
        cycle("empty_pp", 1, 1, 0, 0, 8'h66);
        check("empty_pp_head", 32'(read_data), 32'h66);

        // Wrap-around at constant level.
        for (int i = 0; i < 10; i++) cycle("wrap", 1, 1, 0, 0, 8'(8'h70 + i));

        // Flush with simultaneous push/pop at level 3.
        cycle("pre_flush", 1, 0, 0, 0, 8'hA1);
        cycle("pre_flush", 1, 0, 0, 0, 8'hA2);
        cycle("flush", 1, 1, 1, 0, 8'hA3);
        check("flush_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle.
        cycle("refill", 1, 0, 0, 0, 8'hB1);
        cycle("refill", 1, 0, 0, 0, 8'hB2);
        #2 nrst = 0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 nrst = 1;
        @(posedge clk); #1;

        // Random traffic with changing watermarks.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_level = 3'($urandom_range(0, 6));
                ae_level = 3'($urandom_range(0, 6));
            end
            d = 8'($urandom);
            cycle("rand", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apbspi_wm_fifo.md
Name: apbspi_wm_fifo

Overview:
Parametrised successor to the SPI data FIFO, used for the TX and RX data paths between the APB register file and the SPI shift engine. It adds the following over the basic FIFO:
- an occupancy count;
- programmable almost-full and almost-empty watermarks;
- a one-cycle watermark-crossing event for interrupt generation;
- sticky overflow and underflow error flags.

Illegal pushes and pops are dropped, never corrupting state.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two >=2 (elaboration-time assertion)
LVL_W, $clog2(DEPTH)+1, derived; width of level and watermark values

Ports:
clk  in  1  system clock, all state updates on rising edge
nrst  in  1  asynchronous active-low reset
push  in  1  write request; accepted when !full, or when full with pop in the same cycle
pop  in  1  read request; accepted only when !empty
flush  in  1  synchronous clear of contents
err_clr  in  1  synchronous clear of both sticky error flags
write_data  in  WIDTH  data written on an accepted push
af_level  in  LVL_W  almost-full watermark
ae_level  in  LVL_W  almost-empty watermark
read_data  out  WIDTH  head entry (first-word fall-through); undefined when empty
level  out  LVL_W  current occupancy, 0..DEPTH
empty  out  1  level==0
full  out  1  level==DEPTH
almost_full  out  1  level>=af_level
almost_empty  out  1  level<=ae_level
af_event  out  1  one-cycle pulse when level rises from <af_level to >=af_level
overflow  out  1  sticky: push dropped because full with no pop
underflow  out  1  sticky: pop dropped because empty

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous, active-low (nrst), applied to all control state.
- Reset values: write pointer, read pointer and level = 0; empty=1; full=0; af_event=0; overflow=0; underflow=0.
  - almost_full and almost_empty follow their combinational definitions from level=0.
  - Storage array is not reset.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - level is a separate LVL_W-bit register; full/empty are derived from it.
- Accept rules, evaluated per cycle from registered state:
  - push_ok = push & (!full | pop)
  - pop_ok = pop & !empty
  - Push on an accepted push writes write_data to mem[wr_ptr] and increments wr_ptr; pop on an accepted pop increments rd_ptr.
  - level update: +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
  - Full with push and pop together: both accepted, level stays DEPTH, no overflow.
  - Empty with push and pop together: push accepted, pop dropped, underflow set, level becomes 1.
- read_data: combinational mem[rd_ptr]. A pushed word is visible the cycle after the push (latency 1).
- flush:
  - Has priority over push and pop in the same cycle; both are ignored.
  - Next cycle: pointers = 0, level = 0.
  - Does not clear overflow or underflow. af_event is not generated by a flush.
- Sticky errors:
  - overflow set the cycle after push & full & !pop.
  - underflow set the cycle after pop & empty.
  - err_clr clears both. If a set condition and err_clr occur in the same cycle, set wins.
- af_event:
  - Registered; asserted for exactly one cycle after an edge where the old level < af_level and the new level >= af_level.
  - Not generated by changes of af_level itself.
- Watermark range:
  - af_level=0 makes almost_full constantly 1, and af_event never fires.
  - Values > DEPTH make almost_full constantly 0.
- No other state machine; the block is pointer/counter datapath only.

Test Plan:
- Reset and fill (WIDTH=8, DEPTH=4, af_level=3, ae_level=1): reset, push 0x11,0x22,0x33,0x44 on consecutive cycles → level 1,2,3,4; af_event single pulse on the cycle level becomes 3; full=1 at level 4; read_data=0x11 throughout.
- Overflow: with full FIFO, push 0x55 with pop=0 → level stays 4, overflow=1 next cycle, contents unchanged; err_clr → overflow=0.
- Simultaneous at full: push 0x55 + pop → level 4, read_data goes 0x11→0x22; drain 4 pops yields 0x22,0x33,0x44,0x55, then empty=1, no underflow.
- Underflow and empty push+pop: pop on empty → underflow=1, level 0; push 0x66 + pop on empty → level 1, read_data=0x66 next cycle, underflow stays set.
- Wrap-around: 10 cycles of push+pop after one priming push with incrementing data → ordering preserved across pointer wrap, level constant at 1.
- Flush and reset mid-operation: at level 3, flush+push+pop together → level 0, empty=1, overflow/underflow unchanged; refill to 2, assert nrst low mid-cycle → level 0, empty=1, errors 0 immediately without a clock edge.
